// File: rtl/fpu_sig_div_iter.sv
// Iterative restoring significand divider: quo = {floor(a*2^(MW+1)/b), sticky}.
// Latency: MW+2 cycles after accept for the normal path, 1 cycle for zero/divide-by-zero operands.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_valid && out_ready.
module fpu_sig_div_iter #(
  parameter int MW    = 24,
  parameter int TAG_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MW-1:0]    sig_a,
  input  logic [MW-1:0]    sig_b,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MW+2:0]    quo,
  output logic [TAG_W-1:0] tag_out,
  output logic             dbz,
  output logic             busy
);

  localparam int QW = MW + 3;
  localparam int CW = $clog2(MW + 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [MW:0]      rem_q;
  logic [CW-1:0]    cnt_q;
  logic [MW-1:0]    div_q;
  logic [MW+1:0]    q_q;
  logic             sticky_q;
  logic             dbz_q;
  logic [TAG_W-1:0] tag_q;

  logic             accept;
  logic             handoff;
  logic             b_zero;
  logic             a_zero;
  logic [MW:0]      div_ext;
  logic             ge;
  logic [MW:0]      diff;
  logic [MW:0]      rem_next;
  logic             last_step;

  assign accept    = in_valid && in_ready;
  assign handoff   = out_valid && out_ready;
  assign b_zero    = (sig_b == '0);
  assign a_zero    = (sig_a == '0);
  assign last_step = (cnt_q == '0);

  // One restoring step; rem < 2*div always holds, so the shifted difference fits in MW+1 bits.
  assign div_ext  = {1'b0, div_q};
  assign ge       = (rem_q >= div_ext);
  assign diff     = ge ? (rem_q - div_ext) : rem_q;
  assign rem_next = diff << 1;

  // State register with asynchronous clear to IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush dominates accept and handoff.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (accept) state_d = (b_zero || a_zero) ? S_DONE : S_CALC;
        S_CALC: if (last_step) state_d = S_DONE;
        S_DONE: if (handoff) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      S_IDLE:  in_ready  = 1'b1;
      S_CALC:  busy      = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // Operand capture on accept and quotient accumulation MSB-first during CALC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_q    <= '0;
      cnt_q    <= '0;
      div_q    <= '0;
      q_q      <= '0;
      sticky_q <= 1'b0;
      dbz_q    <= 1'b0;
      tag_q    <= '0;
    end else if (!flush) begin
      if (accept) begin
        tag_q <= tag_in;
        div_q <= sig_b;
        if (b_zero) begin
          q_q      <= '1;
          sticky_q <= 1'b1;
          dbz_q    <= 1'b1;
          rem_q    <= '0;
          cnt_q    <= '0;
        end else if (a_zero) begin
          q_q      <= '0;
          sticky_q <= 1'b0;
          dbz_q    <= 1'b0;
          rem_q    <= '0;
          cnt_q    <= '0;
        end else begin
          q_q      <= '0;
          sticky_q <= 1'b0;
          dbz_q    <= 1'b0;
          rem_q    <= {1'b0, sig_a};
          cnt_q    <= CW'(MW + 1);
        end
      end else if (state_q == S_CALC) begin
        q_q   <= {q_q[MW:0], ge};
        rem_q <= rem_next;
        cnt_q <= cnt_q - CW'(1);
        if (last_step) begin
          sticky_q <= (rem_next != '0);
        end
      end
    end
  end

  assign quo     = QW'({q_q, sticky_q});
  assign tag_out = tag_q;
  assign dbz     = dbz_q;

endmodule

// File: tb/tb_fpu_sig_div_iter.sv
module tb_fpu_sig_div_iter;

  localparam int MW = 24;
  localparam int TW = 10;
  localparam int QW = MW + 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [MW-1:0] sig_a = '0;
  logic [MW-1:0] sig_b = '0;
  logic [TW-1:0] tag_in = '0;
  logic          in_ready, out_valid, dbz, busy;
  logic [QW-1:0] quo;
  logic [TW-1:0] tag_out;

  // MW=8 instance
  logic          p8_vld = 1'b0, p8_ordy = 1'b0;
  logic [7:0]    p8_a = '0, p8_b = '0;
  logic [TW-1:0] p8_tag = 10'h2A5;
  logic          p8_rdy, p8_ovld, p8_dbz, p8_busy;
  logic [10:0]   p8_quo;
  logic [TW-1:0] p8_tago;

  // MW=53 instance
  logic          p53_vld = 1'b0, p53_ordy = 1'b0;
  logic [52:0]   p53_a = '0, p53_b = '0;
  logic [TW-1:0] p53_tag = 10'h13C;
  logic          p53_rdy, p53_ovld, p53_dbz, p53_busy;
  logic [55:0]   p53_quo;
  logic [TW-1:0] p53_tago;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fpu_sig_div_iter #(.MW(MW), .TAG_W(TW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .sig_a(sig_a), .sig_b(sig_b), .tag_in(tag_in), .out_valid(out_valid),
    .out_ready(out_ready), .quo(quo), .tag_out(tag_out), .dbz(dbz), .busy(busy)
  );

  fpu_sig_div_iter #(.MW(8), .TAG_W(TW)) dut8 (
    .clk(clk), .reset(reset), .flush(1'b0), .in_valid(p8_vld), .in_ready(p8_rdy),
    .sig_a(p8_a), .sig_b(p8_b), .tag_in(p8_tag), .out_valid(p8_ovld),
    .out_ready(p8_ordy), .quo(p8_quo), .tag_out(p8_tago), .dbz(p8_dbz), .busy(p8_busy)
  );

  fpu_sig_div_iter #(.MW(53), .TAG_W(TW)) dut53 (
    .clk(clk), .reset(reset), .flush(1'b0), .in_valid(p53_vld), .in_ready(p53_rdy),
    .sig_a(p53_a), .sig_b(p53_b), .tag_in(p53_tag), .out_valid(p53_ovld),
    .out_ready(p53_ordy), .quo(p53_quo), .tag_out(p53_tago), .dbz(p53_dbz), .busy(p53_busy)
  );

  // Reference: {floor(a*2^(mw+1)/b), remainder != 0}
  function automatic logic [127:0] ref_quo(input logic [127:0] a, input logic [127:0] b, input int mw);
    logic [127:0] n, q, r;
    n = a << (mw + 1);
    q = n / b;
    r = n % b;
    return (q << 1) | {127'd0, (r != 0)};
  endfunction

  // Random normalised significand of width mw (MSB set).
  function automatic logic [63:0] rnd_norm(input int mw);
    logic [63:0] v;
    v = {$urandom, $urandom};
    v = v & ((64'd1 << mw) - 64'd1);
    v[mw-1] = 1'b1;
    return v;
  endfunction

  // Present one operation to the main DUT; lat = edges after the accept edge until out_valid seen.
  task automatic do_op(input logic [MW-1:0] a, input logic [MW-1:0] b, input logic [TW-1:0] t,
                       output int lat);
    sig_a = a; sig_b = b; tag_in = t; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({in_ready, out_valid, busy, dbz} !== 4'b1000 || quo !== '0 || tag_out !== '0) begin
      fails++;
      $display("FAIL reset_state: got rdy=%b vld=%b busy=%b dbz=%b quo=%h tag=%h, want 1 0 0 0 0 0",
               in_ready, out_valid, busy, dbz, quo, tag_out);
    end
    tests++;
    if (p8_rdy !== 1'b1 || p53_rdy !== 1'b1 || p8_ovld !== 1'b0 || p53_ovld !== 1'b0) begin
      fails++;
      $display("FAIL reset_state_wide: got rdy8=%b rdy53=%b vld8=%b vld53=%b, want 1 1 0 0",
               p8_rdy, p53_rdy, p8_ovld, p53_ovld);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_directed();
    logic [MW-1:0] va [8];
    logic [MW-1:0] vb [8];
    logic [QW-1:0] vq [8];
    logic          vd [8];
    int            vl [8];
    int            lat;
    logic [TW-1:0] t;
    va = '{24'h800000, 24'hC00000, 24'h800000, 24'hFFFFFF, 24'h800000, 24'h800000, 24'h000000, 24'h000000};
    vb = '{24'h800000, 24'h800000, 24'hC00000, 24'h800000, 24'hFFFFFF, 24'h000000, 24'h900000, 24'h000000};
    vq = '{27'h4000000, 27'h6000000, 27'h2AAAAAB, 27'h7FFFFF8, 27'h2000003, 27'h7FFFFFF, 27'h0000000, 27'h7FFFFFF};
    vd = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vl = '{26, 26, 26, 26, 26, 0, 0, 0};
    for (int i = 0; i < 8; i++) begin
      t = TW'(i * 37 + 5);
      do_op(va[i], vb[i], t, lat);
      tests++;
      if (lat != vl[i] || quo !== vq[i] || dbz !== vd[i] || tag_out !== t || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL directed_%0d: got lat=%0d quo=%h dbz=%b tag=%h rdy=%b, want lat=%0d quo=%h dbz=%b tag=%h rdy=0",
                 i, lat, quo, dbz, tag_out, in_ready, vl[i], vq[i], vd[i], t);
      end
      take();
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        fails++;
        $display("FAIL handoff_%0d: got rdy=%b vld=%b, want 1 0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_stall();
    int lat;
    do_op(24'hC00000, 24'h800000, 10'h3FF, lat);
    for (int c = 0; c < 5; c++) begin
      // Competing operands must be ignored while the result is pending.
      sig_a = 24'h900000; sig_b = 24'hA00000; tag_in = 10'h001; in_valid = 1'b1;
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quo !== 27'h6000000 || tag_out !== 10'h3FF || dbz !== 1'b0) begin
        fails++;
        $display("FAIL stall_%0d: got vld=%b rdy=%b quo=%h tag=%h dbz=%b, want 1 0 6000000 3ff 0",
                 c, out_valid, in_ready, quo, tag_out, dbz);
      end
    end
    in_valid = 1'b0;
    take();
    tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL stall_release: got rdy=%b busy=%b vld=%b, want 1 0 0", in_ready, busy, out_valid);
    end
  endtask

  task automatic test_flush();
    int lat;
    int seen;
    sig_a = 24'h800000; sig_b = 24'hC00000; tag_in = 10'h0AA; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_calc: got rdy=%b busy=%b vld=%b, want 1 0 0", in_ready, busy, out_valid);
    end
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL flush_no_result: got %0d valid cycles, want 0", seen);
    end
    // Flush in DONE wins over handoff and drops the result.
    do_op(24'h800000, 24'h800000, 10'h055, lat);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL flush_done: got vld=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
    // Flush wins over accept.
    sig_a = 24'h800000; sig_b = 24'h800000; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL flush_over_accept: got busy=%b vld=%b rdy=%b, want 0 0 1", busy, out_valid, in_ready);
    end
    do_op(24'hC00000, 24'h800000, 10'h111, lat);
    tests++;
    if (lat != 26 || quo !== 27'h6000000 || tag_out !== 10'h111) begin
      fails++;
      $display("FAIL after_flush: got lat=%0d quo=%h tag=%h, want 26 6000000 111", lat, quo, tag_out);
    end
    take();
  endtask

  task automatic test_reset_mid();
    int lat;
    sig_a = 24'h800000; sig_b = 24'hC00000; tag_in = 10'h155; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    tests++;
    if ({in_ready, out_valid, busy, dbz} !== 4'b1000 || quo !== '0 || tag_out !== '0) begin
      fails++;
      $display("FAIL reset_mid: got rdy=%b vld=%b busy=%b dbz=%b quo=%h tag=%h, want 1 0 0 0 0 0",
               in_ready, out_valid, busy, dbz, quo, tag_out);
    end
    #1 reset = 1'b1;
    do_op(24'h800000, 24'hFFFFFF, 10'h2C3, lat);
    tests++;
    if (lat != 26 || quo !== 27'h2000003 || tag_out !== 10'h2C3 || dbz !== 1'b0) begin
      fails++;
      $display("FAIL after_reset: got lat=%0d quo=%h tag=%h dbz=%b, want 26 2000003 2c3 0", lat, quo, tag_out, dbz);
    end
    take();
  endtask

  task automatic test_random_mw24();
    logic [63:0]  a, b;
    logic [127:0] e;
    int lat;
    for (int i = 0; i < 12; i++) begin
      a = rnd_norm(24); b = rnd_norm(24);
      e = ref_quo({64'd0, a}, {64'd0, b}, 24);
      do_op(a[23:0], b[23:0], TW'(i), lat);
      tests++;
      if (lat != 26 || quo !== e[26:0] || dbz !== 1'b0) begin
        fails++;
        $display("FAIL rand24_%0d: a=%h b=%h got lat=%0d quo=%h, want 26 %h", i, a, b, lat, quo, e[26:0]);
      end
      take();
    end
  endtask

  task automatic test_random_mw8();
    logic [63:0]  a, b;
    logic [127:0] e;
    int n;
    for (int i = 0; i < 12; i++) begin
      a = rnd_norm(8); b = rnd_norm(8);
      e = ref_quo({64'd0, a}, {64'd0, b}, 8);
      p8_a = a[7:0]; p8_b = b[7:0]; p8_vld = 1'b1;
      @(posedge clk); #1;
      p8_vld = 1'b0;
      n = 0;
      while (!p8_ovld && n < 80) begin
        @(posedge clk); #1;
        n++;
      end
      tests++;
      if (n != 10 || p8_quo !== e[10:0] || p8_dbz !== 1'b0 || p8_busy !== 1'b0 || p8_tago !== p8_tag) begin
        fails++;
        $display("FAIL rand8_%0d: a=%h b=%h got lat=%0d quo=%h dbz=%b, want 10 %h 0", i, a[7:0], b[7:0], n, p8_quo, p8_dbz, e[10:0]);
      end
      p8_ordy = 1'b1;
      @(posedge clk); #1;
      p8_ordy = 1'b0;
    end
  endtask

  task automatic test_random_mw53();
    logic [63:0]  a, b;
    logic [127:0] e;
    int n;
    for (int i = 0; i < 12; i++) begin
      a = rnd_norm(53); b = rnd_norm(53);
      if (i == 0) b = a;
      e = ref_quo({64'd0, a}, {64'd0, b}, 53);
      p53_a = a[52:0]; p53_b = b[52:0]; p53_vld = 1'b1;
      @(posedge clk); #1;
      p53_vld = 1'b0;
      n = 0;
      while (!p53_ovld && n < 80) begin
        @(posedge clk); #1;
        n++;
      end
      tests++;
      if (n != 55 || p53_quo !== e[55:0] || p53_dbz !== 1'b0 || p53_busy !== 1'b0 || p53_tago !== p53_tag) begin
        fails++;
        $display("FAIL rand53_%0d: a=%h b=%h got lat=%0d quo=%h dbz=%b, want 55 %h 0", i, a, b, n, p53_quo, p53_dbz, e[55:0]);
      end
      p53_ordy = 1'b1;
      @(posedge clk); #1;
      p53_ordy = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_flush();
    test_reset_mid();
    test_random_mw24();
    test_random_mw8();
    test_random_mw53();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fpu_sig_div_iter.md
FPU_SIG_DIV_ITER -- requirements
Module: fpu_sig_div_iter

Interface
REQ-001 Parameter MW, default 24: significand width in bits, hidden bit included; legal range 4..64.
REQ-002 Parameter TAG_W, default 10: width of the side-band tag (sign/exponent) carried alongside the operation.
REQ-003 Derived width QW = MW+3: quotient output width (MW+2 quotient bits plus 1 sticky bit).
REQ-004 clk  input  1  Single clock; all state updates on the rising edge.
REQ-005 reset  input  1  Asynchronous, active-low reset.
REQ-006 flush  input  1  Synchronous abort of any operation in progress.
REQ-007 in_valid  input  1  Operands and tag are valid this cycle.
REQ-008 in_ready  output  1  The block can accept operands; high only in IDLE.
REQ-009 sig_a  input  MW  Dividend significand, either normalised (MSB=1) or all-zero.
REQ-010 sig_b  input  MW  Divisor significand, either normalised (MSB=1) or all-zero.
REQ-011 tag_in  input  TAG_W  Side-band tag, captured on accept.
REQ-012 out_valid  output  1  Result is valid; held until accepted.
REQ-013 out_ready  input  1  Consumer accepts the result.
REQ-014 quo  output  QW  {q_raw[MW+1:0], sticky}.
REQ-015 tag_out  output  TAG_W  Tag captured on accept.
REQ-016 dbz  output  1  Divide-by-zero flag for the current result.
REQ-017 busy  output  1  High in CALC.

Function
REQ-018 The block SHALL have three states: IDLE, CALC, DONE.
REQ-019 Accept SHALL occur on an edge where in_valid && in_ready; the edge captures sig_a, sig_b and tag_in.
REQ-020 When sig_b==0 at accept, the block SHALL go IDLE->DONE with quo = all ones and dbz=1, so out_valid is high in the cycle after accept.
REQ-021 When sig_a==0 and sig_b!=0 at accept, the block SHALL go IDLE->DONE with quo=0 and dbz=0.
REQ-022 Otherwise the block SHALL go IDLE->CALC with an (MW+1)-bit remainder rem set to sig_a and an iteration counter set to MW+1.
REQ-023 Each CALC edge SHALL perform one restoring step:
- if rem>=sig_b: quotient bit[cnt]=1 and rem=(rem-sig_b)<<1;
- else: bit[cnt]=0 and rem=rem<<1;
- cnt decrements.
REQ-024 The invariant rem<2*sig_b SHALL hold throughout, so MW+1 remainder bits never overflow.
REQ-025 After exactly MW+2 CALC edges (the step with cnt==0), the block SHALL enter DONE.
REQ-026 In DONE, sticky SHALL equal (final remainder != 0).
REQ-027 q_raw SHALL equal floor(sig_a*2^(MW+1)/sig_b).
REQ-028 Normal-path latency: with accept at edge k, out_valid SHALL first be high after edge k+MW+2.
REQ-029 quo[QW-1] SHALL be 1 iff sig_a>=sig_b, which gives the downstream normaliser its 1-bit shift decision.
REQ-030 out_valid, quo, dbz and tag_out SHALL remain stable in DONE until out_valid && out_ready; that edge returns the block to IDLE.
REQ-031 in_ready SHALL be low in DONE; there is no accept in the same cycle as result handoff.
REQ-032 flush SHALL return the block to IDLE on the next edge from any state, dropping any result; flush takes priority over accept and handoff.
REQ-033 in_valid while in_ready is low SHALL be ignored, and operands SHALL NOT be re-sampled.
REQ-034 busy SHALL equal (state==CALC).

Reset
REQ-035 While reset==0, the block SHALL be in IDLE with in_ready=1, out_valid=0, busy=0, dbz=0, quo=0, tag_out=0, and rem and counter cleared.
REQ-036 Reset assertion SHALL take effect immediately and asynchronously, including mid-CALC and in DONE; the pending result is lost.
REQ-037 After reset deasserts, the first accept SHALL be possible on the first rising edge.

Verification
REQ-038 MW=24, sig_a=0x800000, sig_b=0x800000 -> after 26 cycles quo=0x4000000, dbz=0; tag_out equals tag_in.
REQ-039 MW=24, sig_a=0xC00000, sig_b=0x800000 -> quo=0x6000000.
REQ-040 MW=24, sig_a=0x800000, sig_b=0xC00000 -> quo=0x2AAAAAB (sticky=1, MSB=0).
REQ-041 sig_b=0 -> out_valid in the next cycle with quo=0x7FFFFFF and dbz=1; with sig_a=0, sig_b=0x900000 -> quo=0, dbz=0, 1-cycle.
REQ-042 out_ready held low 5 cycles in DONE -> outputs stable and in_ready=0; flush at CALC cycle 10 -> IDLE next cycle with out_valid never asserted.
REQ-043 reset pulsed low mid-CALC -> all outputs at reset values immediately; a new operation then completes correctly.
REQ-044 A randomised run with MW in {8,24,53} SHALL compare quo against a reference model floor(a*2^(MW+1)/b) plus sticky.
